// File: rtl/uart_pkg.sv
// Shared definitions for the ISP download UART receiver.
// Provides the receiver state encoding, the fixed 8N1 frame constants and
// the default clock divider (50 MHz system clock, 115200 baud).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned STOP_BITS       = 1;
    localparam int unsigned DEFAULT_CLK_DIV = 434;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and byte output bundle of the UART receiver.
//   rxd     serial line into the receiver (idle high)
//   rddata  last correctly framed byte
//   rdflag  one-cycle pulse when rddata updates
//   ferr    one-cycle pulse on a framing error
//   busy    receiver is inside a frame
// Modports: slave = the receiver, master = whoever drives the line and
// consumes the bytes (word packer or testbench).
interface uart_rx_if;
    logic       rxd;
    logic [7:0] rddata;
    logic       rdflag;
    logic       ferr;
    logic       busy;

    modport slave  (input  rxd, output rddata, output rdflag, output ferr, output busy);
    modport master (output rxd, input  rddata, input  rdflag, input  ferr, input  busy);
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for one asynchronous input.
//   clk    destination clock
//   rst_n  synchronous active-low reset; both flops load RST_VAL
//   d_i    asynchronous input
//   q_o    synchronised output, two cycles behind d_i
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: clocked state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours; = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver for the ISP download path.
//   CLK_DIV  clocks per bit, 8..65535
//   clk      system clock
//   rst_n    synchronous active-low reset
//   bus      uart_rx_if.slave: rxd in; rddata, rdflag, ferr, busy out
// Start bit is re-checked at half a bit time, then every bit (data and stop)
// is sampled one full bit time after the previous sample, i.e. mid-bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);

    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    logic        rxd_s;
    uart_state_e state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q,   shift_d;
    logic [7:0]  rddata_q,  rddata_d;
    logic        rdflag_q,  rdflag_d;
    logic        ferr_q,    ferr_d;
    logic        armed_q,   armed_d;
    logic [1:0]  fill_q;

    sync2 #(.RST_VAL(1'b1)) u_sync_rxd (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.rxd),
        .q_o   (rxd_s)
    );

    // The synchroniser leaves reset holding 1, which is not a real line
    // observation. fill_q marks when rxd_s actually reflects the pin, so a
    // line held low across reset never arms the receiver.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= 2'b00;
        end else begin
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rddata_d  = rddata_q;
        rdflag_d  = 1'b0;
        ferr_d    = 1'b0;
        armed_d   = armed_q | (fill_q[1] & rxd_s);

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (armed_q && !rxd_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        rddata_d = shift_q;
                        rdflag_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the datapath registers (shift, rddata) are reset along with the
    // control state so a reset mid-frame leaves nothing stale visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rddata_q  <= '0;
            rdflag_q  <= 1'b0;
            ferr_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rddata_q  <= rddata_d;
            rdflag_q  <= rdflag_d;
            ferr_q    <= ferr_d;
            armed_q   <= armed_d;
        end
    end

    assign bus.rddata = rddata_q;
    assign bus.rdflag = rdflag_q;
    assign bus.ferr   = ferr_q;
    assign bus.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with CLK_DIV = 16 (H = 8).
// Inputs change 1 ns after a rising edge; outputs are observed on falling
// edges by a monitor that logs pulses and models the downstream word packer.
module tb_uart_rx;

    localparam int BIT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    uart_rx_if bus ();

    uart_rx #(.CLK_DIV(BIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    // Pulse log and downstream packer model.
    int         flag_cyc[$];
    logic [7:0] flag_dat[$];
    int         ferr_cyc[$];
    bit         busy_seen = 1'b0;
    logic       prev_flag = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [31:0] pk_word  = '0;
    int          pk_n     = 0;
    logic [15:0] pk_addr  = '0;
    logic [31:0] wr_data[$];
    logic [15:0] wr_addr[$];

    always @(negedge clk) begin
        if (bus.rdflag === 1'b1 || bus.ferr === 1'b1) begin
            n_vec++;
            if ((bus.rdflag && bus.ferr) || (bus.rdflag && prev_flag) || (bus.ferr && prev_ferr)) begin
                n_err++;
                $display("FAIL pulse_shape cyc=%0d rdflag=%b ferr=%b prev_rdflag=%b prev_ferr=%b, required single isolated pulses",
                         cyc, bus.rdflag, bus.ferr, prev_flag, prev_ferr);
            end
        end
        if (bus.rdflag === 1'b1) begin
            flag_cyc.push_back(cyc);
            flag_dat.push_back(bus.rddata);
            if (prev_flag !== 1'b1) begin
                pk_word = {bus.rddata, pk_word[31:8]};
                pk_n++;
                if (pk_n == 4) begin
                    wr_data.push_back(pk_word);
                    wr_addr.push_back(pk_addr);
                    pk_addr = pk_addr + 16'd1;
                    pk_n    = 0;
                end
            end
        end
        if (bus.ferr === 1'b1) ferr_cyc.push_back(cyc);
        if (bus.busy === 1'b1) busy_seen = 1'b1;
        prev_flag = bus.rdflag;
        prev_ferr = bus.ferr;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rxd = b;
        tick(BIT);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    function automatic logic [7:0] dat_at(input int idx);
        if (idx < flag_dat.size()) return flag_dat[idx];
        return 8'hxx;
    endfunction

    // Sends one byte and checks it arrives as exactly one new rdflag pulse.
    task automatic expect_byte(input logic [7:0] b, input string name);
        int base;
        base = flag_dat.size();
        send_byte(b);
        tick(4);
        n_vec++;
        if (flag_dat.size() - base !== 1 || dat_at(base) !== b) begin
            n_err++;
            $display("FAIL %s pulses=%0d data=%h, required 1 pulse data=%h",
                     name, flag_dat.size() - base, dat_at(base), b);
        end
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        bus.rxd = 1'b1;
        tick(3);
        n_vec++;
        if (bus.rddata !== 8'h00 || bus.rdflag !== 1'b0 || bus.ferr !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state rddata=%h rdflag=%b ferr=%b busy=%b, required 00 0 0 0",
                     bus.rddata, bus.rdflag, bus.ferr, bus.busy);
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_stream;
        logic [7:0] exp_b[4];
        int base, wbase;
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        base  = flag_dat.size();
        wbase = wr_data.size();
        for (int i = 0; i < 4; i++) send_byte(exp_b[i]);
        tick(4);
        n_vec++;
        if (flag_dat.size() - base !== 4) begin
            n_err++;
            $display("FAIL stream_count pulses=%0d, required 4", flag_dat.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (dat_at(base + i) !== exp_b[i]) begin
                n_err++;
                $display("FAIL stream_byte%0d got=%h, required %h", i, dat_at(base + i), exp_b[i]);
            end
        end
        n_vec++;
        if (wr_data.size() - wbase !== 1) begin
            n_err++;
            $display("FAIL packer_writes got=%0d, required 1", wr_data.size() - wbase);
        end else if (wr_data[wbase] !== 32'h12345678 || wr_addr[wbase] !== 16'h0000) begin
            n_err++;
            $display("FAIL packer_word wrdata=%h wraddr=%h, required 12345678 at 0000",
                     wr_data[wbase], wr_addr[wbase]);
        end
    endtask

    task automatic test_single_byte;
        int base, fbase, k;
        base  = flag_cyc.size();
        fbase = ferr_cyc.size();
        k     = cyc;
        send_byte(8'hA5);
        tick(4);
        n_vec++;
        if (flag_cyc.size() - base !== 1) begin
            n_err++;
            $display("FAIL single_count pulses=%0d, required 1", flag_cyc.size() - base);
        end else if (flag_cyc[base] !== k + 155) begin
            // pin falls in cycle k, rxd_s in k+2 = t0, pulse at t0+153
            n_err++;
            $display("FAIL single_timing pulse_cyc=%0d, required %0d", flag_cyc[base], k + 155);
        end
        n_vec++;
        if (dat_at(base) !== 8'hA5 || bus.rddata !== 8'hA5 || ferr_cyc.size() !== fbase) begin
            n_err++;
            $display("FAIL single_data pulse_data=%h rddata=%h ferr_pulses=%0d, required A5 A5 0",
                     dat_at(base), bus.rddata, ferr_cyc.size() - fbase);
        end
    endtask

    task automatic test_glitch;
        int base, fbase, k;
        base  = flag_cyc.size();
        fbase = ferr_cyc.size();
        k     = cyc;
        bus.rxd = 1'b0;
        tick(4);
        bus.rxd = 1'b1;
        tick(6);
        @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_hold cyc=%0d busy=%b, required 1", cyc - k, bus.busy);
        end
        @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy_drop cyc=%0d busy=%b, required 0", cyc - k, bus.busy);
        end
        @(posedge clk);
        #1;
        tick(20);
        n_vec++;
        if (flag_cyc.size() !== base || ferr_cyc.size() !== fbase) begin
            n_err++;
            $display("FAIL glitch_output rdflags=%0d ferrs=%0d, required 0 0",
                     flag_cyc.size() - base, ferr_cyc.size() - fbase);
        end
        expect_byte(8'h3C, "glitch_next_byte");
    endtask

    task automatic test_framing;
        int base, fbase, k;
        expect_byte(8'h11, "framing_first_byte");
        base  = flag_cyc.size();
        fbase = ferr_cyc.size();
        k     = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        send_bit(1'b0);
        repeat (40) send_bit(1'b0);
        bus.rxd = 1'b1;
        tick(40);
        n_vec++;
        if (ferr_cyc.size() - fbase !== 1) begin
            n_err++;
            $display("FAIL framing_ferr_count got=%0d, required 1", ferr_cyc.size() - fbase);
        end else if (ferr_cyc[fbase] !== k + 155) begin
            n_err++;
            $display("FAIL framing_ferr_timing cyc=%0d, required %0d", ferr_cyc[fbase], k + 155);
        end
        n_vec++;
        if (flag_cyc.size() !== base || bus.rddata !== 8'h11) begin
            n_err++;
            $display("FAIL framing_hold rdflags=%0d rddata=%h, required 0 11",
                     flag_cyc.size() - base, bus.rddata);
        end
        expect_byte(8'h5A, "framing_next_byte");
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        int base, fbase;
        b = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        bus.rxd = b[3];
        tick(8);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.rddata !== 8'h00) begin
            n_err++;
            $display("FAIL midframe_reset busy=%b rddata=%h, required 0 00", bus.busy, bus.rddata);
        end
        base      = flag_cyc.size();
        fbase     = ferr_cyc.size();
        busy_seen = 1'b0;
        tick(7);
        for (int i = 4; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
        tick(20);
        n_vec++;
        if (flag_cyc.size() !== base || ferr_cyc.size() !== fbase || busy_seen !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_tail rdflags=%0d ferrs=%0d busy_seen=%b, required 0 0 0",
                     flag_cyc.size() - base, ferr_cyc.size() - fbase, busy_seen);
        end
        expect_byte(8'h81, "midframe_next_byte");
    endtask

    task automatic test_break_at_reset;
        int base, fbase;
        bus.rxd = 1'b0;
        rst_n   = 1'b0;
        tick(3);
        base      = flag_cyc.size();
        fbase     = ferr_cyc.size();
        busy_seen = 1'b0;
        rst_n     = 1'b1;
        tick(50);
        bus.rxd = 1'b1;
        tick(40);
        n_vec++;
        if (busy_seen !== 1'b0 || ferr_cyc.size() !== fbase || flag_cyc.size() !== base) begin
            n_err++;
            $display("FAIL break_at_reset busy_seen=%b ferrs=%0d rdflags=%0d, required 0 0 0",
                     busy_seen, ferr_cyc.size() - fbase, flag_cyc.size() - base);
        end
        expect_byte(8'hE7, "break_next_byte");
    endtask

    initial begin
        bus.rxd = 1'b1;
        @(posedge clk);
        #1;
        test_reset;
        test_stream;
        test_single_byte;
        test_glitch;
        test_framing;
        test_reset_midframe;
        test_break_at_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-oriented UART receiver for the ISP download path. It converts the serial `rxd` line into 8-bit bytes on `rddata`. Each accepted byte is announced with a one-cycle `rdflag` pulse, which the downstream word packer edge-detects before assembling 32-bit words for program RAM. The frame format is fixed 8N1, LSB first. Over-sampling is by a parameterised clock divider.

## Interface
- `CLK_DIV`, default 434: clocks per bit (50 MHz / 115200); legal range 8..65535.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rxd`  in  1  asynchronous serial line; idle high.
- `rddata`  out  8  last correctly framed byte; held until the next good byte.
- `rdflag`  out  1  one-cycle pulse, high in the cycle `rddata` updates.
- `ferr`  out  1  one-cycle pulse on a framing error (stop bit sampled 0).
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser to produce `rxd_s`. Both synchroniser flops reset to 1.
- `H = CLK_DIV/2`, using integer floor.
- One counter, 16 bits wide, counts bit time. It clears on every state change and on every sample.
- A 3-bit counter counts data bits. The 8-bit shift register shifts right, and the new bit enters at bit 7.
- The `armed` flag clears on reset. It sets on the first cycle with `rxd_s==1`. A start bit is only detected while `armed` is set.
- States:
  - IDLE: if `armed` and `rxd_s==0`, go to START.
  - START: when the counter reaches `H-1`, sample `rxd_s`.
    - If it is 0, go to DATA.
    - If it is 1, this was a glitch: go to IDLE. No output.
  - DATA: every `CLK_DIV` cycles, sample `rxd_s` into the shift register.
    - After the 8th sample, go to STOP.
  - STOP: after `CLK_DIV` cycles, sample `rxd_s`.
    - If it is 1: load the shift register into `rddata`, pulse `rdflag`, go to IDLE.
    - If it is 0: pulse `ferr`, leave `rddata` unchanged, go to BREAK.
  - BREAK: wait for `rxd_s==1`, then go to IDLE. A held-low line (break condition) yields exactly one `ferr` and no spurious bytes.
- `rdflag` and `ferr` are never high in the same cycle. Neither output is ever high for two consecutive cycles.
- `rdflag` is registered. It drops the cycle after it rises, so the downstream edge detector sees one rising edge per byte.
- Reset mid-frame: on the next edge the block returns to IDLE and the partial byte is discarded. `rddata` resets to 0. A line that is still low after reset is ignored until it has been high once (`armed`).

## Timing
- Reset values:
  - `rddata` = 0x00, `rdflag` = 0, `ferr` = 0, `busy` = 0.
  - state IDLE, both counters 0, shift register 0x00, `armed` = 0.
- `rxd_s` lags the pin by 2 cycles.
- Let t0 be the first cycle with `rxd_s==0` in IDLE while `armed`.
  - Start sample at t0+H.
  - Data bit i (0..7) sampled at t0+H+(i+1)·`CLK_DIV`.
  - Stop sample at t0+H+9·`CLK_DIV`.
  - `rdflag`/`ferr` high during cycle t0+H+9·`CLK_DIV`+1 only.
- `busy` is high from t0+1 through the stop-sample cycle, or until BREAK exits.
- Back-to-back frames: IDLE is reached one cycle after the stop sample, about `CLK_DIV`/2 before the nominal stop-bit end. A next start bit at the minimum spacing is therefore detected with no loss.
- Tolerated baud mismatch is about ±4 % (mid-bit sampling).

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - 8N1 constants: `DATA_BITS` = 8, stop bits = 1
  - default `CLK_DIV`
- Sub-module `sync2`: a 2-flop synchroniser with a parameterised reset value (1 here). It is reusable for other asynchronous ISP inputs.

## Test plan
All directed tests use `CLK_DIV` = 16, so H = 8.
- **Single byte:** send 0xA5 as 8N1.
  - `rdflag` is high for exactly 1 cycle at t0+153.
  - `rddata` = 0xA5 from then on; `ferr` stays 0.
- **Stream into the word packer:** send 0x78, 0x56, 0x34, 0x12 with minimum spacing into the downstream packer.
  - Four `rdflag` pulses with `rddata` = 0x78, 0x56, 0x34, 0x12 in order.
  - The packer writes `wrdata` = 0x12345678 at `wraddr` = 0x0000.
- **Glitch:** pull `rxd` low for 4 cycles, then release it.
  - No `rdflag` and no `ferr`.
  - `busy` drops at t0+9, and the next valid byte 0x3C is received correctly.
- **Framing error:** receive 0x11, then send 0xFF with the stop bit 0, then hold the line low for 40 bit times, then release it.
  - Exactly one `ferr` pulse; `rdflag` stays 0 and `rddata` stays 0x11.
  - A following byte 0x5A is received.
- **Reset mid-frame:** assert `rst_n` = 0 for 1 cycle during data bit 3 of 0xC3.
  - Next cycle: `busy` = 0 and `rddata` = 0x00.
  - The remaining bits produce no `rdflag`; the next byte 0x81 is received correctly.
- **Break at reset:** hold `rxd` low through reset release for 50 cycles, then raise it.
  - No start is detected, no `ferr`, and `busy` stays 0.
